// File: rtl/aes_stream_core.sv
// aes_stream_core: AES-128 encryption engine with valid/ready streaming.
// A plaintext is accepted with a valid/ready handshake and encrypted over
// STEPS = 10/UNROLL clock cycles, with UNROLL rounds evaluated per cycle.
// The result is held until the sink accepts it. The key lives in its own
// register and can only be loaded while the engine is idle.
// Optional feature: define AES_BLKCNT_EN to add the 32-bit oBlkCnt counter.
module aes_stream_core #(
  parameter int UNROLL = 1
) (
  input  logic         iClk,
  input  logic         iRsn,
  input  logic         iKeyLd,
  input  logic [127:0] iAesKey,
  input  logic         iInVld,
  output logic         oInRdy,
  input  logic [127:0] iPlainText,
  output logic         oOutVld,
  input  logic         iOutRdy,
  output logic [127:0] oCpText,
  output logic         oBusy
`ifdef AES_BLKCNT_EN
  ,
  output logic [31:0]  oBlkCnt
`endif
);

  localparam int STEPS = 10 / UNROLL;
  localparam logic [3:0] LAST_STEP = 4'(STEPS - 1);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5)) begin : g_bad_unroll
    $error("aes_stream_core: UNROLL must be 1, 2 or 5");
  end

  localparam logic [7:0] SBOX_C [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Round helpers. Byte i of the 128-bit state sits at [127-8i -: 8]
  // and maps to row i%4, column i/4 (column-major, as in FIPS-197).
  // ---------------------------------------------------------------------
  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_C[b];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] r;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int w = 0; w < 4; w++) begin
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    case (idx)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [127:0] next_round_key(input logic [127:0] rk, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  state_e       fsm_q;
  logic [127:0] key_q;
  logic [127:0] state_q;
  logic [127:0] rkey_q;
  logic [3:0]   step_q;
  logic [127:0] ct_q;
  logic         out_vld_q;
  logic         busy_q;
  logic         idle_q;

  logic [127:0] key_sel_s;
  logic [127:0] rnd_st_s;
  logic [127:0] rnd_rk_s;

  // A key presented together with a block in IDLE is used for that block.
  always_comb begin
    key_sel_s = key_q;
    if (idle_q && iKeyLd) begin
      key_sel_s = iAesKey;
    end else begin
      key_sel_s = key_q;
    end
  end

  // Evaluate UNROLL consecutive rounds, expanding the round key alongside.
  always_comb begin
    logic [127:0] st_v;
    logic [127:0] rk_v;
    logic [3:0]   idx;
    st_v = state_q;
    rk_v = rkey_q;
    idx  = 4'd0;
    for (int u = 0; u < UNROLL; u++) begin
      idx  = step_q * 4'(UNROLL) + 4'(u);
      rk_v = next_round_key(rk_v, rcon(idx));
      if (idx == 4'd9) begin
        st_v = shift_rows(sub_bytes(st_v)) ^ rk_v;
      end else begin
        st_v = mix_columns(shift_rows(sub_bytes(st_v))) ^ rk_v;
      end
    end
    rnd_st_s = st_v;
    rnd_rk_s = rk_v;
  end

  assign oInRdy  = idle_q | (out_vld_q & iOutRdy);
  assign oOutVld = out_vld_q;
  assign oCpText = ct_q;
  assign oBusy   = busy_q;

  // Control FSM plus datapath registers: accept, iterate, hold the result.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      fsm_q     <= ST_IDLE;
      key_q     <= 128'h0;
      state_q   <= 128'h0;
      rkey_q    <= 128'h0;
      step_q    <= 4'd0;
      ct_q      <= 128'h0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      idle_q    <= 1'b1;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          if (iKeyLd) begin
            key_q <= iAesKey;
          end
          if (iInVld) begin
            state_q <= iPlainText ^ key_sel_s;
            rkey_q  <= key_sel_s;
            step_q  <= 4'd0;
            fsm_q   <= ST_RUN;
            busy_q  <= 1'b1;
            idle_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          state_q <= rnd_st_s;
          rkey_q  <= rnd_rk_s;
          if (step_q == LAST_STEP) begin
            ct_q      <= rnd_st_s;
            out_vld_q <= 1'b1;
            step_q    <= 4'd0;
            fsm_q     <= ST_HOLD;
          end else begin
            step_q <= step_q + 4'd1;
          end
        end
        ST_HOLD: begin
          // The output handshake can coincide with the next accept.
          if (iOutRdy) begin
            out_vld_q <= 1'b0;
            if (iInVld) begin
              state_q <= iPlainText ^ key_q;
              rkey_q  <= key_q;
              step_q  <= 4'd0;
              fsm_q   <= ST_RUN;
            end else begin
              fsm_q  <= ST_IDLE;
              busy_q <= 1'b0;
              idle_q <= 1'b1;
            end
          end
        end
        default: begin
          fsm_q     <= ST_IDLE;
          out_vld_q <= 1'b0;
          busy_q    <= 1'b0;
          idle_q    <= 1'b1;
        end
      endcase
    end
  end

`ifdef AES_BLKCNT_EN
  logic [31:0] blk_cnt_q;

  // Count completed output handshakes; wraps naturally at 2^32.
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      blk_cnt_q <= 32'd0;
    end else if (out_vld_q && iOutRdy) begin
      blk_cnt_q <= blk_cnt_q + 32'd1;
    end
  end

  assign oBlkCnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_aes_stream_core.sv
// Self-checking bench for aes_stream_core: FIPS-197 vectors, backpressure,
// back-to-back, simultaneous key/data, mid-run reset and random blocks
// checked against a byte-level AES-128 reference model.
module tb_aes_stream_core;

  parameter int UNROLL = 1;
  localparam int STEPS = 10 / UNROLL;

  localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         clk;
  logic         rst_n;
  logic         key_ld;
  logic [127:0] aes_key;
  logic         in_vld;
  logic         in_rdy;
  logic [127:0] pt;
  logic         out_vld;
  logic         out_rdy;
  logic [127:0] ct;
  logic         busy;
`ifdef AES_BLKCNT_EN
  logic [31:0]  blkcnt;
  int           hs_exp;
`endif

  int n_cmp;
  int n_mis;
  logic [7:0] sb_tbl [256];

  aes_stream_core #(.UNROLL(UNROLL)) dut (
    .iClk       (clk),
    .iRsn       (rst_n),
    .iKeyLd     (key_ld),
    .iAesKey    (aes_key),
    .iInVld     (in_vld),
    .oInRdy     (in_rdy),
    .iPlainText (pt),
    .oOutVld    (out_vld),
    .iOutRdy    (out_rdy),
    .oCpText    (ct),
    .oBusy      (busy)
`ifdef AES_BLKCNT_EN
    ,
    .oBlkCnt    (blkcnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] p_in);
    logic [7:0] w [44][4];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] tmp [4];
    logic [7:0] rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) begin
      w[i/4][i%4] = key[127-8*i -: 8];
      s[i]        = p_in[127-8*i -: 8];
    end
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) tmp[j] = sb_tbl[w[i-1][(j+1)%4]];
        tmp[0] = tmp[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i/4][i%4];
    for (int n = 1; n <= 10; n++) begin
      for (int i = 0; i < 16; i++) t[i] = sb_tbl[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
      if (n < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*n + i/4][i%4];
    end
    res = 128'h0;
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- check / drive helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait for oOutVld while scrambling inputs that must have no effect.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_vld && lat < 64) begin
      aes_key = rnd128();
      pt      = rnd128();
      key_ld  = 1'($urandom);
      step();
      lat++;
    end
    key_ld = 1'b0;
  endtask

  // Present one block from IDLE, then wait for its result.
  task automatic send_block(input logic ld, input logic [127:0] k, input logic [127:0] p,
                            input string tag, output int lat);
    key_ld = ld; aes_key = k; pt = p; in_vld = 1'b1;
    #1;
    chk({tag, "_inrdy"}, 128'(in_rdy), 128'd1);
    @(posedge clk);
    #1;
    key_ld = 1'b0; in_vld = 1'b0;
    chk({tag, "_busy"}, 128'(busy), 128'd1);
    wait_result(lat);
    chk({tag, "_latency"}, 128'(lat), 128'(STEPS));
  endtask

  // Complete the output handshake and return to IDLE.
  task automatic drain(input string tag);
    out_rdy = 1'b1; in_vld = 1'b0;
    step();
    chk({tag, "_vld_drop"}, 128'(out_vld), 128'd0);
    chk({tag, "_idle"}, 128'(busy), 128'd0);
`ifdef AES_BLKCNT_EN
    hs_exp++;
    chk({tag, "_blkcnt"}, 128'(blkcnt), 128'(hs_exp));
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int rwait;
    logic [127:0] k, p, exp_ct;
    n_cmp = 0; n_mis = 0;
`ifdef AES_BLKCNT_EN
    hs_exp = 0;
`endif
    for (int i = 0; i < 256; i++) sb_tbl[i] = sbox_calc(8'(i));

    // Reset state
    rst_n = 1'b0; key_ld = 1'b0; aes_key = 128'h0; in_vld = 1'b0; pt = 128'h0; out_rdy = 1'b0;
    step(); step();
    chk("rst_inrdy", 128'(in_rdy), 128'd1);
    chk("rst_outvld", 128'(out_vld), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_ct", ct, 128'h0);
`ifdef AES_BLKCNT_EN
    chk("rst_blkcnt", 128'(blkcnt), 128'd0);
`endif
    rst_n = 1'b1;
    step();

    // FIPS-197 C.1 with key and data in the same IDLE cycle
    out_rdy = 1'b1;
    send_block(1'b1, KEY_C1, PT_C1, "c1", lat);
    chk("c1_ct", ct, CT_C1);
    chk("c1_hold_inrdy", 128'(in_rdy), 128'd1);
    drain("c1");

    // FIPS-197 B with the key loaded on its own first
    key_ld = 1'b1; aes_key = KEY_B;
    step();
    key_ld = 1'b0;
    send_block(1'b0, ~KEY_B, PT_B, "b", lat);
    chk("b_ct", ct, CT_B);
    drain("b");

    // Backpressure: 20 stalled cycles, key load attempt during HOLD
    out_rdy = 1'b0;
    p = rnd128();
    exp_ct = aes_ref(KEY_B, p);
    send_block(1'b0, rnd128(), p, "bp", lat);
    chk("bp_ct", ct, exp_ct);
    in_vld = 1'b1; pt = rnd128();
    for (int i = 0; i < 20; i++) begin
      key_ld = (i == 5); aes_key = KEY_C1;
      step();
      chk("bp_ct_stable", ct, exp_ct);
      chk("bp_inrdy", 128'(in_rdy), 128'd0);
      chk("bp_outvld", 128'(out_vld), 128'd1);
    end
    key_ld = 1'b0;
    drain("bp");
    p = rnd128();
    send_block(1'b0, KEY_C1, p, "bp_next", lat);
    chk("bp_next_ct", ct, aes_ref(KEY_B, p));
    drain("bp_next");

    // Back-to-back: accept coincides with the output handshake
    out_rdy = 1'b1;
    send_block(1'b0, rnd128(), PT_C1, "b2b1", lat);
    chk("b2b1_ct", ct, aes_ref(KEY_B, PT_C1));
    in_vld = 1'b1; pt = PT_B; aes_key = KEY_C1;
    #1;
    chk("b2b_inrdy", 128'(in_rdy), 128'd1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
`ifdef AES_BLKCNT_EN
    hs_exp++;
`endif
    chk("b2b_vld_drop", 128'(out_vld), 128'd0);
    chk("b2b_busy", 128'(busy), 128'd1);
    wait_result(lat);
    chk("b2b2_latency", 128'(lat), 128'(STEPS));
    chk("b2b2_ct", ct, CT_B);
    drain("b2b2");

    // Random keys, plaintexts, load modes and sink stalls
    for (int n = 0; n < 6; n++) begin
      k = rnd128();
      p = rnd128();
      out_rdy = 1'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        send_block(1'b1, k, p, "rnd_sim", lat);
      end else begin
        key_ld = 1'b1; aes_key = k;
        step();
        key_ld = 1'b0;
        send_block(1'b0, ~k, p, "rnd_sep", lat);
      end
      exp_ct = aes_ref(k, p);
      chk("rnd_ct", ct, exp_ct);
      out_rdy = 1'b0;
      repeat ($urandom_range(0, 3)) step();
      chk("rnd_ct_held", ct, exp_ct);
      drain("rnd");
    end

    // Mid-run reset discards the block and clears everything at once
    rwait = (STEPS > 4) ? 4 : 1;
    in_vld = 1'b1; pt = rnd128();
    step();
    in_vld = 1'b0;
    repeat (rwait) step();
    chk("mid_busy", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mrst_inrdy", 128'(in_rdy), 128'd1);
    chk("mrst_outvld", 128'(out_vld), 128'd0);
    chk("mrst_busy", 128'(busy), 128'd0);
    chk("mrst_ct", ct, 128'h0);
`ifdef AES_BLKCNT_EN
    hs_exp = 0;
    chk("mrst_blkcnt", 128'(blkcnt), 128'd0);
`endif
    step();
    rst_n = 1'b1;
    step();
    chk("mrst_after_outvld", 128'(out_vld), 128'd0);

    // Key register was cleared by reset
    p = rnd128();
    out_rdy = 1'b1;
    send_block(1'b0, KEY_B, p, "zkey", lat);
    chk("zkey_ct", ct, aes_ref(128'h0, p));
    drain("zkey");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
